cnn_result_drain: RTL and testbench

Read-out stage downstream of the CNN top level. After the controller finishes a convolution run, this block reads the packed 64-bit result words from port B of the output memory, `CNN_outMEM`. It streams them to the host/bus side over a valid/ready interface. A credit-limited prefetch into a small FIFO hides the 1-cycle SRAM read latency and sustains one word per cycle under back-pressure.

---
 rtl/cnn_pkg.sv | 12 +
 rtl/cnn_drain_fifo.sv | 56 +++++
 rtl/cnn_result_drain.sv | 143 ++++++++++++++
 tb/tb_cnn_result_drain.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN word geometry and result-drain FSM state type
package cnn_pkg;
    localparam int CNN_WORD_WIDTH = 64;
    localparam int CNN_LANES      = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } drain_state_e;
endpackage

// File: rtl/cnn_drain_fifo.sv
// rtl/cnn_drain_fifo.sv - prefetch FIFO between output SRAM read data and the result stream
module cnn_drain_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (PW+1)'(DEPTH));
    assign count     = r_count;
    assign rdata     = r_mem[r_rd_ptr];
    assign w_do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= wdata;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + (PW+1)'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - (PW+1)'(1);
            end
        end
    end
endmodule

// File: rtl/cnn_result_drain.sv
// rtl/cnn_result_drain.sv - streams CNN_outMEM result words out over valid/ready; CNN_DRAIN_RELU_EN adds lane ReLU
module cnn_result_drain
    import cnn_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int WORD_WIDTH = CNN_WORD_WIDTH,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] num_words,
    output logic                  mem_cen_b,
    output logic                  mem_wen_b,
    output logic [ADDR_WIDTH-1:0] mem_addr_b,
    input  logic [WORD_WIDTH-1:0] mem_q_b,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WORD_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    drain_state_e          r_state;
    drain_state_e          w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_num_words;
    logic [ADDR_WIDTH-1:0] r_issue_idx;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic                  w_issue;
    logic                  w_is_last_issue;
    logic                  w_pop;
    logic                  w_drained;
    logic                  w_credit_ok;
    logic                  w_empty;
    logic                  w_full;
    logic [CW-1:0]         w_count;
    logic [CW:0]           w_used;
    logic [WORD_WIDTH:0]   w_head;
    logic [WORD_WIDTH-1:0] w_head_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = (num_words == '0) ? FINISH : READ;
            READ:    if (w_issue && w_is_last_issue) w_next_state = DRAIN;
            DRAIN:   if (w_drained) w_next_state = FINISH;
            FINISH:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_issue = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (r_state)
            READ: begin
                w_issue = w_credit_ok;
                busy    = 1'b1;
            end
            DRAIN:   busy = 1'b1;
            FINISH:  done = 1'b1;
            default: ;
        endcase
    end

    // Credit: words already buffered plus the read in flight, less the word leaving now.
    assign w_pop           = m_valid & m_ready;
    assign w_used          = {1'b0, w_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
    assign w_credit_ok     = (w_used < (CW+1)'(FIFO_DEPTH)) && !(w_full && !w_pop);
    assign w_is_last_issue = (r_issue_idx == r_num_words - ADDR_WIDTH'(1));
    assign w_drained       = !r_inflight && (w_empty || (w_count == CW'(1) && w_pop));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr          <= '0;
            r_num_words     <= '0;
            r_issue_idx     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            if (r_state == IDLE && start) begin
                r_addr      <= base_addr;
                r_num_words <= num_words;
                r_issue_idx <= '0;
            end else if (w_issue) begin
                r_addr      <= r_addr + ADDR_WIDTH'(1);
                r_issue_idx <= r_issue_idx + ADDR_WIDTH'(1);
            end
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue & w_is_last_issue;
        end
    end

    assign mem_cen_b  = ~w_issue;
    assign mem_wen_b  = 1'b1;
    assign mem_addr_b = r_addr;

    cnn_drain_fifo #(
        .WIDTH (WORD_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (r_inflight),
        .wdata ({r_inflight_last, mem_q_b}),
        .pop   (w_pop),
        .rdata (w_head),
        .count (w_count),
        .empty (w_empty),
        .full  (w_full)
    );

    assign m_valid     = ~w_empty;
    assign m_last      = w_head[WORD_WIDTH];
    assign w_head_data = w_head[WORD_WIDTH-1:0];

`ifdef CNN_DRAIN_RELU_EN
    localparam int LANES = WORD_WIDTH / 8;

    always_comb begin
        m_data = w_head_data;
        for (int l = 0; l < LANES; l++) begin
            if (w_head_data[l*8+7]) m_data[l*8 +: 8] = 8'h00;
        end
    end
`else
    assign m_data = w_head_data;
`endif
endmodule

// File: tb/tb_cnn_result_drain.sv
// tb/tb_cnn_result_drain.sv - directed self-checking bench for cnn_result_drain
module tb_cnn_result_drain;
    localparam int AW = 10;
    localparam int WW = 64;
    localparam int DEPTH = 2;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] num_words;
    logic          mem_cen_b;
    logic          mem_wen_b;
    logic [AW-1:0] mem_addr_b;
    logic [WW-1:0] mem_q_b;
    logic          m_valid;
    logic          m_ready;
    logic [WW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          done;

    logic [WW-1:0] mem [1024];
    int            n_total = 0;
    int            n_pass = 0;
    int            n_fail = 0;
    int            done_cnt = 0;
    time           done_t = 0;
    logic          done_busy = 1'b0;
    int            issued = 0;
    int            popped = 0;
    int            credit_viol = 0;
    int            stall_viol = 0;
    logic          prev_stall = 1'b0;
    logic [WW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    logic [WW-1:0] rx_data [$];
    logic          rx_last [$];
    time           rx_t [$];
    logic [AW-1:0] cen_log [$];
    time           t_e0 = 0;
    int            wrap_a [4] = '{1022, 1023, 0, 1};

    cnn_result_drain #(
        .ADDR_WIDTH (AW),
        .WORD_WIDTH (WW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .num_words  (num_words),
        .mem_cen_b  (mem_cen_b),
        .mem_wen_b  (mem_wen_b),
        .mem_addr_b (mem_addr_b),
        .mem_q_b    (mem_q_b),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000ns");
        $fatal(1);
    end

    always @(posedge clk) begin
        if (!mem_cen_b) mem_q_b <= mem[mem_addr_b];
    end

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            done_t    = $time;
            done_busy = busy;
        end
        if (!reset) begin
            issued     = 0;
            popped     = 0;
            prev_stall = 1'b0;
        end else begin
            if (!mem_cen_b) begin
                if (issued - popped - ((m_valid && m_ready) ? 1 : 0) >= DEPTH) credit_viol++;
                issued++;
                cen_log.push_back(mem_addr_b);
            end
            if (m_valid && m_ready) begin
                popped++;
                rx_data.push_back(m_data);
                rx_last.push_back(m_last);
                rx_t.push_back($time);
            end
            if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) stall_viol++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    function automatic logic [63:0] exp_word(input int k);
        logic [63:0] w;
        w = 64'(k) * 64'h0101010101010101;
`ifdef CNN_DRAIN_RELU_EN
        for (int l = 0; l < 8; l++) begin
            if (w[l*8+7]) w[l*8 +: 8] = 8'h00;
        end
`endif
        return w;
    endfunction

    function automatic int cyc_of(input time t);
        return int'((t - t_e0 - 5) / 10);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
        check({tag, "_m_data"}, m_data, 64'd0);
        check({tag, "_m_last"}, 64'(m_last), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_cen"}, 64'(mem_cen_b), 64'd1);
        check({tag, "_wen"}, 64'(mem_wen_b), 64'd1);
        check({tag, "_addr"}, 64'(mem_addr_b), 64'd0);
    endtask

    task automatic clear_logs();
        rx_data.delete();
        rx_last.delete();
        rx_t.delete();
        cen_log.delete();
    endtask

    task automatic start_drain(input int b, input int n);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = AW'(b);
        num_words = AW'(n);
        @(posedge clk);
        t_e0 = $time;
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int c0;
        c0 = done_cnt;
        for (int i = 0; i < 400 && done_cnt == c0; i++) @(posedge clk);
        check({tag, "_done_seen"}, 64'(done_cnt - c0), 64'd1);
        #1;
    endtask

    initial begin
        int c0;
        int lasts;
        reset     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        num_words = '0;
        m_ready   = 1'b0;
        for (int k = 0; k < 1024; k++) mem[k] = 64'(k) * 64'h0101010101010101;
        mem[700] = 64'h80FF7F01_00C0407F;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        @(posedge clk);
        #1 reset = 1'b1;

        // Basic 5-word drain from address 4 with the consumer always ready.
        m_ready = 1'b1;
        clear_logs();
        start_drain(4, 5);
        wait_done("t1");
        check("t1_count", 64'(rx_data.size()), 64'd5);
        for (int i = 0; i < 5 && i < rx_data.size(); i++) begin
            check($sformatf("t1_data%0d", i), rx_data[i], exp_word(4 + i));
            check($sformatf("t1_last%0d", i), 64'(rx_last[i]), (i == 4) ? 64'd1 : 64'd0);
            check($sformatf("t1_cyc%0d", i), 64'(cyc_of(rx_t[i])), 64'(i + 2));
        end
        check("t1_done_cyc", 64'(cyc_of(done_t)), 64'd7);
        check("t1_done_busy", 64'(done_busy), 64'd0);
        check("t1_reads", 64'(cen_log.size()), 64'd5);

        // 64 words with a randomly stalling consumer.
        m_ready = 1'b0;
        clear_logs();
        start_drain(100, 64);
        c0 = done_cnt;
        for (int i = 0; i < 2000 && done_cnt == c0; i++) begin
            @(posedge clk);
            #1 m_ready = 1'($urandom_range(0, 1));
        end
        check("t2_done_seen", 64'(done_cnt - c0), 64'd1);
        m_ready = 1'b1;
        check("t2_count", 64'(rx_data.size()), 64'd64);
        lasts = 0;
        for (int i = 0; i < rx_data.size(); i++) begin
            check($sformatf("t2_data%0d", i), rx_data[i], exp_word(100 + i));
            if (rx_last[i]) lasts++;
        end
        check("t2_last_count", 64'(lasts), 64'd1);
        if (rx_last.size() == 64) check("t2_last_pos", 64'(rx_last[63]), 64'd1);
        check("t2_reads", 64'(cen_log.size()), 64'd64);
        check("t2_stall_stable", 64'(stall_viol), 64'd0);
        check("t2_credit", 64'(credit_viol), 64'd0);

        // Address wrap at the top of the memory.
        clear_logs();
        start_drain(1022, 4);
        wait_done("t3");
        check("t3_reads", 64'(cen_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < cen_log.size() && i < rx_data.size(); i++) begin
            check($sformatf("t3_addr%0d", i), 64'(cen_log[i]), 64'(wrap_a[i]));
            check($sformatf("t3_data%0d", i), rx_data[i], exp_word(wrap_a[i]));
        end

        // Zero-length drain.
        clear_logs();
        start_drain(50, 0);
        wait_done("t4");
        check("t4_done_cyc", 64'(cyc_of(done_t)), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t4_reads", 64'(cen_log.size()), 64'd0);
        check("t4_words", 64'(rx_data.size()), 64'd0);

        // Second start while busy is ignored.
        clear_logs();
        start_drain(200, 10);
        check("t5_busy", 64'(busy), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = AW'(500);
        num_words = AW'(3);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("t5");
        c0 = done_cnt;
        repeat (6) @(posedge clk);
        #1;
        check("t5_no_extra_done", 64'(done_cnt - c0), 64'd0);
        check("t5_count", 64'(rx_data.size()), 64'd10);
        check("t5_reads", 64'(cen_log.size()), 64'd10);
        for (int i = 0; i < rx_data.size(); i++) begin
            check($sformatf("t5_data%0d", i), rx_data[i], exp_word(200 + i));
        end

        // Reset dropped mid-drain, then a fresh drain.
        clear_logs();
        start_drain(300, 10);
        for (int i = 0; i < 100 && rx_data.size() < 3; i++) @(posedge clk);
        check("t6_reached_word3", 64'(rx_data.size() >= 3), 64'd1);
        #1 reset = 1'b0;
        #1;
        check_reset_vals("t6");
        c0 = done_cnt;
        repeat (3) @(posedge clk);
        check("t6_no_done", 64'(done_cnt - c0), 64'd0);
        #1 reset = 1'b1;
        clear_logs();
        start_drain(600, 3);
        wait_done("t6");
        check("t6_count", 64'(rx_data.size()), 64'd3);
        if (cen_log.size() > 0) check("t6_first_addr", 64'(cen_log[0]), 64'd600);
        for (int i = 0; i < rx_data.size(); i++) begin
            check($sformatf("t6_data%0d", i), rx_data[i], exp_word(600 + i));
        end

        // Lane ReLU vector (pass-through unless the feature is built in).
        clear_logs();
        start_drain(700, 1);
        wait_done("t7");
        check("t7_count", 64'(rx_data.size()), 64'd1);
        if (rx_data.size() > 0) begin
`ifdef CNN_DRAIN_RELU_EN
            check("t7_data", rx_data[0], 64'h00007F01_0000407F);
`else
            check("t7_data", rx_data[0], 64'h80FF7F01_00C0407F);
`endif
            check("t7_last", 64'(rx_last[0]), 64'd1);
        end
        check("final_credit", 64'(credit_viol), 64'd0);
        check("final_stall", 64'(stall_viol), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
